// File: rtl/da_pkg.sv
// ----------------------------------------------------------------------------
// da_pkg
//   Shared definitions for the multi-channel D/A frame player.
//   - FSM state encodings (2-bit constants)
//   - clog2_min1(): ceil(log2(n)) clamped to at least 1, so a width derived
//     from a parameter equal to 1 never collapses to a zero-width vector.
// ----------------------------------------------------------------------------
package da_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;  // no samples on channel 0
    localparam logic [1:0] S_LOAD = 2'd1;  // samples present, waiting for play
    localparam logic [1:0] S_PLAY = 2'd2;  // frame replay in progress
    localparam logic [1:0] S_DONE = 2'd3;  // one-cycle wrap-up after a frame

    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/da_chan_buf.sv
// ----------------------------------------------------------------------------
// da_chan_buf
//   One channel's sample store: DEPTH x DW registers filled in order, plus a
//   fill counter. Read is combinational at rd_idx_i and returns 0 for any
//   index not yet written, so short channels pad the frame with silence.
//
// Ports
//   clk_i      system clock (rising edge)
//   rst_n_i    synchronous reset, active low; clears the fill count
//   clr_i      flush: fill count to 0, write suppressed
//   we_i       write strobe (already qualified by the top)
//   din_i      sample to append
//   rd_idx_i   replay index
//   rd_data_o  sample at rd_idx_i, or 0 beyond the fill count
//   fill_o     number of samples held, 0..DEPTH
// ----------------------------------------------------------------------------
module da_chan_buf
    import da_pkg::*;
#(
    parameter  int DW    = 8,
    parameter  int DEPTH = 8,
    localparam int IW    = clog2_min1(DEPTH),
    localparam int FW    = IW + 1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          clr_i,
    input  logic          we_i,
    input  logic [DW-1:0] din_i,
    input  logic [IW-1:0] rd_idx_i,
    output logic [DW-1:0] rd_data_o,
    output logic [FW-1:0] fill_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [FW-1:0] fill_q, fill_d;
    logic          wr_en;

    // Local guard against a full buffer so the array index can never wrap
    // onto sample 0, whatever the caller does.
    assign wr_en = we_i && !clr_i && (fill_q < FW'(DEPTH));

    always_comb begin
        fill_d = fill_q;
        if (clr_i)
            fill_d = '0;
        else if (wr_en)
            fill_d = fill_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i)
            fill_q <= '0;
        else
            fill_q <= fill_d;
    end

    // Sample storage carries no reset: contents are meaningless until the
    // fill count covers them.
    always_ff @(posedge clk_i) begin
        if (wr_en)
            mem_q[fill_q[IW-1:0]] <= din_i;
    end

    assign rd_data_o = ({1'b0, rd_idx_i} < fill_q) ? mem_q[rd_idx_i] : '0;
    assign fill_o    = fill_q;

endmodule

// File: rtl/da_frame_player.sv
// ----------------------------------------------------------------------------
// da_frame_player
//   Multi-channel D/A sample buffer. The host appends samples per channel;
//   a rising edge on outflag replays one frame (length = channel 0 fill) to
//   all channels in lock-step, one sample set every DIV cycles. Loop mode
//   keeps replaying while outflag stays high; the frame in flight always
//   completes.
//
// Ports
//   dack     system clock, rising edge
//   reset    synchronous reset, active low
//   we/wch/din  sample write: one sample to channel wch per cycle
//   outflag  play request (rise starts, level keeps a loop going)
//   loop     1 = loop mode, 0 = one-shot; captured at frame start
//   clr      flush all buffers, fill counts and overflow flag
//   dout     channel c at dout[c*DW +: DW]; registered, holds between strobes
//   dstb     one-cycle strobe marking a new sample set on dout
//   busy     high while playing
//   done     one-cycle pulse after a one-shot frame
//   full     channel wch holds DEPTH samples (combinational on wch)
//   ovf      sticky: some write was dropped
// ----------------------------------------------------------------------------
module da_frame_player
    import da_pkg::*;
#(
    parameter  int DW    = 8,
    parameter  int DEPTH = 8,
    parameter  int NCH   = 2,
    parameter  int DIV   = 1,
    localparam int CW    = clog2_min1(NCH),
    localparam int IW    = clog2_min1(DEPTH),
    localparam int FW    = IW + 1,
    localparam int DVW   = clog2_min1(DIV)
) (
    input  logic              dack,
    input  logic              reset,
    input  logic              we,
    input  logic [CW-1:0]     wch,
    input  logic [DW-1:0]     din,
    input  logic              outflag,
    input  logic              loop,
    input  logic              clr,
    output logic [NCH*DW-1:0] dout,
    output logic              dstb,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic              ovf
);

    localparam logic [DVW-1:0] DIV_LAST = DVW'(DIV - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]          state_q,   state_d;
    logic [IW-1:0]       rd_idx_q,  rd_idx_d;
    logic [DVW-1:0]      div_cnt_q, div_cnt_d;
    logic                loop_q,    loop_d;
    logic [NCH*DW-1:0]   dout_q,    dout_d;
    logic                dstb_q,    dstb_d;
    logic                done_q,    done_d;
    logic                ovf_q,     ovf_d;
    logic                of_s_q,    of_p_q;   // outflag sample and its predecessor

    // ------------------------------------------------------------------
    // Channel buffers
    // ------------------------------------------------------------------
    logic [NCH-1:0][FW-1:0] fill;
    logic [NCH-1:0][DW-1:0] rd_data;
    logic [NCH-1:0]         we_ch;

    logic          wch_ok, ch_full, wr_ok;
    logic [FW-1:0] sel_fill, frame_len;
    logic          rise, period_end, last_idx;

    assign wch_ok   = int'({1'b0, wch}) < NCH;
    assign sel_fill = wch_ok ? fill[wch] : '0;
    assign ch_full  = (sel_fill == FW'(DEPTH));

    // clr wins over a same-cycle write; writes are frozen during replay so
    // the frame length cannot move under the read pointer.
    assign wr_ok = we && !clr && (state_q != S_PLAY) && wch_ok && !ch_full;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign we_ch[c] = wr_ok && (wch == CW'(c));

        da_chan_buf #(
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_buf (
            .clk_i     (dack),
            .rst_n_i   (reset),
            .clr_i     (clr),
            .we_i      (we_ch[c]),
            .din_i     (din),
            .rd_idx_i  (rd_idx_q),
            .rd_data_o (rd_data[c]),
            .fill_o    (fill[c])
        );
    end

    // ------------------------------------------------------------------
    // Frame sequencing
    // ------------------------------------------------------------------
    // Channel 0 is the master: its fill count sets the frame length.
    assign frame_len  = fill[0];
    assign last_idx   = ({1'b0, rd_idx_q} == (frame_len - FW'(1)));
    assign period_end = (div_cnt_q == DIV_LAST);

    // Rise is taken from registered samples, which puts busy one cycle
    // after the edge that first sees outflag high.
    assign rise = of_s_q && !of_p_q;

    always_comb begin
        state_d   = state_q;
        rd_idx_d  = rd_idx_q;
        div_cnt_d = div_cnt_q;
        loop_d    = loop_q;
        dout_d    = dout_q;
        dstb_d    = 1'b0;
        done_d    = 1'b0;
        ovf_d     = ovf_q | (we && !wr_ok);

        if (clr) begin
            state_d   = S_IDLE;
            rd_idx_d  = '0;
            div_cnt_d = '0;
            dout_d    = '0;
            ovf_d     = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (frame_len != '0)
                        state_d = S_LOAD;
                end
                S_LOAD: begin
                    if (rise) begin
                        state_d   = S_PLAY;
                        loop_d    = loop;
                        rd_idx_d  = '0;
                        div_cnt_d = '0;
                    end
                end
                S_PLAY: begin
                    // Each sample owns a DIV-cycle slot: strobe at the start
                    // of the slot, step the index at its end. The end-of-frame
                    // decision is taken at the end of the last slot so a loop
                    // wrap keeps the strobe period at exactly DIV.
                    if (div_cnt_q == '0) begin
                        dout_d = rd_data;
                        dstb_d = 1'b1;
                    end
                    if (period_end) begin
                        div_cnt_d = '0;
                        if (last_idx) begin
                            rd_idx_d = '0;
                            if (!(loop_q && outflag))
                                state_d = S_DONE;
                        end else begin
                            rd_idx_d = rd_idx_q + 1'b1;
                        end
                    end else begin
                        div_cnt_d = div_cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_d = S_LOAD;
                    done_d  = !loop_q;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge dack) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            rd_idx_q  <= '0;
            div_cnt_q <= '0;
            loop_q    <= 1'b0;
            dout_q    <= '0;
            dstb_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            of_s_q    <= 1'b0;
            of_p_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_idx_q  <= rd_idx_d;
            div_cnt_q <= div_cnt_d;
            loop_q    <= loop_d;
            dout_q    <= dout_d;
            dstb_q    <= dstb_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            of_s_q    <= outflag;
            of_p_q    <= of_s_q;
        end
    end

    assign dout = dout_q;
    assign dstb = dstb_q;
    assign busy = (state_q == S_PLAY);
    assign done = done_q;
    assign full = wch_ok && ch_full;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_da_frame_player.sv
// Bench for da_frame_player: two instances share all inputs, one at DIV=1
// (u_d1) and one at DIV=3 (u_d3). Expected sample sets are queued as the
// buffers are loaded and popped as strobes appear.
module tb_da_frame_player;
    import da_pkg::*;

    logic        dack = 1'b0;
    logic        reset = 1'b0;
    logic        we = 1'b0;
    logic [0:0]  wch = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        outflag = 1'b0;
    logic        loop = 1'b0;
    logic        clr = 1'b0;

    logic [15:0] dout1, dout3;
    logic        dstb1, busy1, done1, full1, ovf1;
    logic        dstb3, busy3, done3, full3, ovf3;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_q [$];

    always #5 dack = ~dack;

    da_frame_player #(.DW(8), .DEPTH(8), .NCH(2), .DIV(1)) u_d1 (
        .dack(dack), .reset(reset), .we(we), .wch(wch), .din(din),
        .outflag(outflag), .loop(loop), .clr(clr),
        .dout(dout1), .dstb(dstb1), .busy(busy1), .done(done1),
        .full(full1), .ovf(ovf1)
    );

    da_frame_player #(.DW(8), .DEPTH(8), .NCH(2), .DIV(3)) u_d3 (
        .dack(dack), .reset(reset), .we(we), .wch(wch), .din(din),
        .outflag(outflag), .loop(loop), .clr(clr),
        .dout(dout3), .dstb(dstb3), .busy(busy3), .done(done3),
        .full(full3), .ovf(ovf3)
    );

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge dack);
        #1;
    endtask

    task automatic wr(input logic [0:0] ch, input logic [7:0] d);
        we = 1'b1; wch = ch; din = d;
        tick();
        we = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int n;
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if ({dout1, dout3} !== 32'h0) begin
            errors++; $display("FAIL reset_dout: got %h/%h want 0000/0000", dout1, dout3);
        end
        checks++;
        if ({dstb1, busy1, done1, ovf1, full1} !== 5'b0) begin
            errors++; $display("FAIL reset_flags_d1: got %b want 00000", {dstb1, busy1, done1, ovf1, full1});
        end
        checks++;
        if ({dstb3, busy3, done3, ovf3, full3} !== 5'b0) begin
            errors++; $display("FAIL reset_flags_d3: got %b want 00000", {dstb3, busy3, done3, ovf3, full3});
        end
        checks++;
        if (u_d1.state_q !== S_IDLE) begin
            errors++; $display("FAIL reset_state: got %0d want %0d", u_d1.state_q, S_IDLE);
        end
        reset = 1'b1;
        tick();
        outflag = 1'b1;
        n = 0;
        repeat (6) begin
            tick();
            if (dstb1 || dstb3) n++;
        end
        outflag = 1'b0;
        tick();
        checks++;
        if (n != 0 || u_d1.state_q !== S_IDLE) begin
            errors++; $display("FAIL idle_rise: got %0d strobes state %0d want 0 strobes state %0d", n, u_d1.state_q, S_IDLE);
        end
    endtask

    task automatic test_oneshot();
        logic [15:0] e;
        pulse_clr();
        for (int i = 0; i < 8; i++) wr(1'b0, 8'(i + 1));
        for (int i = 0; i < 4; i++) wr(1'b1, 8'(8'hA0 + i));
        for (int i = 0; i < 8; i++) exp_q.push_back({(i < 4) ? 8'(8'hA0 + i) : 8'h00, 8'(i + 1)});
        loop = 1'b0;
        outflag = 1'b1;
        tick();
        checks++;
        if (busy1 !== 1'b0) begin
            errors++; $display("FAIL os_busy_k: got %b want 0", busy1);
        end
        tick();
        checks++;
        if (busy1 !== 1'b1 || dstb1 !== 1'b0) begin
            errors++; $display("FAIL os_busy_k1: got busy %b dstb %b want 1 0", busy1, dstb1);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if (dstb1 !== 1'b1 || dout1 !== e) begin
                errors++; $display("FAIL os_sample%0d: got dstb %b dout %h want 1 %h", i, dstb1, dout1, e);
            end
        end
        tick();
        checks++;
        if (done1 !== 1'b1 || busy1 !== 1'b0 || dstb1 !== 1'b0) begin
            errors++; $display("FAIL os_done: got done %b busy %b dstb %b want 1 0 0", done1, busy1, dstb1);
        end
        tick();
        checks++;
        if (done1 !== 1'b0 || dout1 !== 16'h0008) begin
            errors++; $display("FAIL os_after: got done %b dout %h want 0 0008", done1, dout1);
        end
        outflag = 1'b0;
    endtask

    task automatic test_replay();
        logic [15:0] e;
        for (int i = 0; i < 8; i++) exp_q.push_back({(i < 4) ? 8'(8'hA0 + i) : 8'h00, 8'(i + 1)});
        tick();
        outflag = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if (dstb1 !== 1'b1 || dout1 !== e) begin
                errors++; $display("FAIL replay_sample%0d: got dstb %b dout %h want 1 %h", i, dstb1, dout1, e);
            end
        end
        tick();
        checks++;
        if (done1 !== 1'b1) begin
            errors++; $display("FAIL replay_done: got %b want 1", done1);
        end
        outflag = 1'b0;
        tick();
    endtask

    task automatic test_overflow();
        logic [15:0] e;
        pulse_clr();
        checks++;
        if (ovf1 !== 1'b0) begin
            errors++; $display("FAIL ovf_clr_start: got %b want 0", ovf1);
        end
        for (int i = 0; i < 8; i++) wr(1'b0, 8'(i + 1));
        checks++;
        if (full1 !== 1'b1 || ovf1 !== 1'b0) begin
            errors++; $display("FAIL ovf_full8: got full %b ovf %b want 1 0", full1, ovf1);
        end
        wch = 1'b1;
        #1;
        checks++;
        if (full1 !== 1'b0) begin
            errors++; $display("FAIL ovf_full_wch1: got %b want 0", full1);
        end
        wr(1'b0, 8'hEE);
        checks++;
        if (ovf1 !== 1'b1 || full1 !== 1'b1) begin
            errors++; $display("FAIL ovf_9th: got ovf %b full %b want 1 1", ovf1, full1);
        end
        for (int i = 0; i < 8; i++) exp_q.push_back({8'h00, 8'(i + 1)});
        loop = 1'b0;
        outflag = 1'b1;
        tick();
        tick();
        we = 1'b1; wch = 1'b1; din = 8'h55;
        for (int i = 0; i < 8; i++) begin
            tick();
            we = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if (dstb1 !== 1'b1 || dout1 !== e) begin
                errors++; $display("FAIL ovf_sample%0d: got dstb %b dout %h want 1 %h", i, dstb1, dout1, e);
            end
        end
        checks++;
        if (ovf1 !== 1'b1) begin
            errors++; $display("FAIL ovf_play_write: got %b want 1", ovf1);
        end
        tick();
        tick();
        outflag = 1'b0;
        wch = 1'b0;
        pulse_clr();
        checks++;
        if (ovf1 !== 1'b0 || full1 !== 1'b0 || u_d1.fill[0] !== 4'd0 || u_d1.state_q !== S_IDLE) begin
            errors++; $display("FAIL ovf_clr: got ovf %b full %b fill %0d state %0d want 0 0 0 %0d",
                               ovf1, full1, u_d1.fill[0], u_d1.state_q, S_IDLE);
        end
    endtask

    task automatic test_loop();
        logic [15:0] e;
        int n, last, dn;
        pulse_clr();
        for (int i = 0; i < 4; i++) wr(1'b0, 8'(8'h10 + i));
        for (int i = 0; i < 2; i++) wr(1'b1, 8'(8'h20 + i));
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < 4; i++) exp_q.push_back({(i < 2) ? 8'(8'h20 + i) : 8'h00, 8'(8'h10 + i)});
        loop = 1'b1;
        outflag = 1'b1;
        n = 0; last = 0; dn = 0;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (done3) dn++;
            if (dstb3) begin
                n++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL loop_extra: got strobe %0d dout %h want no strobe", n, dout3);
                end else begin
                    e = exp_q.pop_front();
                    if (dout3 !== e) begin
                        errors++; $display("FAIL loop_sample%0d: got %h want %h", n, dout3, e);
                    end
                end
                checks++;
                if ((n == 1 && c != 3) || (n > 1 && c - last != 3)) begin
                    errors++; $display("FAIL loop_spacing%0d: got cycle %0d (prev %0d) want spacing 3, first at 3", n, c, last);
                end
                last = c;
                if (n == 10) outflag = 1'b0;
            end
        end
        checks++;
        if (n != 12 || dn != 0 || busy3 !== 1'b0) begin
            errors++; $display("FAIL loop_end: got strobes %0d done %0d busy %b want 12 0 0", n, dn, busy3);
        end
        loop = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_abort(input bit use_reset);
        logic [15:0] e;
        int n;
        pulse_clr();
        for (int i = 0; i < 8; i++) wr(1'b0, 8'(8'h31 + i));
        for (int i = 0; i < 8; i++) exp_q.push_back({8'h00, 8'(8'h31 + i)});
        loop = 1'b0;
        outflag = 1'b1;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (dstb1) begin
                e = exp_q.pop_front();
                checks++;
                if (dout1 !== e) begin
                    errors++; $display("FAIL abort_sample%0d: got %h want %h", n, dout1, e);
                end
                n++;
                if (n == 3) break;
            end
        end
        checks++;
        if (n != 3) begin
            errors++; $display("FAIL abort_timeout: got %0d strobes want 3", n);
        end
        if (use_reset) reset = 1'b0; else clr = 1'b1;
        tick();
        reset = 1'b1; clr = 1'b0; outflag = 1'b0;
        checks++;
        if (busy1 !== 1'b0 || dout1 !== 16'h0 || dstb1 !== 1'b0 || u_d1.state_q !== S_IDLE) begin
            errors++; $display("FAIL abort_state(rst=%0d): got busy %b dout %h dstb %b state %0d want 0 0000 0 %0d",
                               use_reset, busy1, dout1, dstb1, u_d1.state_q, S_IDLE);
        end
        n = 0;
        repeat (12) begin
            tick();
            if (dstb1 || done1) n++;
        end
        checks++;
        if (n != 0) begin
            errors++; $display("FAIL abort_quiet(rst=%0d): got %0d strobe/done cycles want 0", use_reset, n);
        end
        exp_q.delete();
    endtask

    task automatic test_we_clr();
        int n;
        wch = 1'b0; din = 8'h77; we = 1'b1; clr = 1'b1;
        tick();
        we = 1'b0; clr = 1'b0;
        tick();
        tick();
        checks++;
        if (u_d1.fill[0] !== 4'd0 || u_d1.state_q !== S_IDLE || ovf1 !== 1'b0) begin
            errors++; $display("FAIL we_clr: got fill %0d state %0d ovf %b want 0 %0d 0",
                               u_d1.fill[0], u_d1.state_q, ovf1, S_IDLE);
        end
        outflag = 1'b1;
        n = 0;
        repeat (5) begin
            tick();
            if (dstb1) n++;
        end
        outflag = 1'b0;
        checks++;
        if (n != 0) begin
            errors++; $display("FAIL we_clr_play: got %0d strobes want 0", n);
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_replay();
        test_overflow();
        test_loop();
        test_abort(1'b0);
        test_abort(1'b1);
        test_we_clr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
